cplx_polar_to_rect: RTL

Iterative CORDIC (rotation mode) unit that converts a complex operand pair given in polar form (magnitude, angle) into rectangular form (real, imag) before it enters the complex ALU path. It is the input-side counterpart of the writeback stage's rectangular-to-polar output formatting. The unit sits between register read and the complex ALU. While it runs, it stalls the pipeline through busy.

---
 rtl/cplx_pkg.sv | 29 ++
 rtl/cordic_rot_step.sv | 34 +++
 rtl/cplx_polar_to_rect.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cplx_pkg.sv
// cplx_pkg: shared FSM state type and Q-format constants for the
// polar-to-rectangular CORDIC unit (angles in Q3.28, 1/K in Q1.31).
package cplx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESCALE,
    ITERATE,
    ROUND,
    DONE
  } state_t;

  localparam logic [31:0] INV_K_Q31 = 32'h4DBA76D4;

  localparam logic signed [31:0] PI_Q      = 32'sh3243F6A9;
  localparam logic signed [31:0] HALF_PI_Q = 32'sh1921FB54;

  // atan(2^-i) in Q3.28, rounded to nearest
  localparam logic signed [31:0] ATAN_TAB [0:27] = '{
    32'sh0C90FDAA, 32'sh076B19C1, 32'sh03EB6EBF, 32'sh01FD5BAA,
    32'sh00FFAADE, 32'sh007FF557, 32'sh003FFEAB, 32'sh001FFFD5,
    32'sh000FFFFB, 32'sh0007FFFF, 32'sh00040000, 32'sh00020000,
    32'sh00010000, 32'sh00008000, 32'sh00004000, 32'sh00002000,
    32'sh00001000, 32'sh00000800, 32'sh00000400, 32'sh00000200,
    32'sh00000100, 32'sh00000080, 32'sh00000040, 32'sh00000020,
    32'sh00000010, 32'sh00000008, 32'sh00000004, 32'sh00000002
  };

endpackage

// File: rtl/cordic_rot_step.sv
// cordic_rot_step: one combinational CORDIC rotation-mode micro-step.
// In: x, y (W-bit signed), z (Q3.28), i. Out: rotated x_rot, y_rot, z_rot.
module cordic_rot_step
  import cplx_pkg::*;
#(
  parameter int W = 42
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [31:0]  z,
  input  logic        [4:0]   i,
  output logic signed [W-1:0] x_rot,
  output logic signed [W-1:0] y_rot,
  output logic signed [31:0]  z_rot
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
    if (!z[31]) begin
      x_rot = x - y_sh;
      y_rot = y + x_sh;
      z_rot = z - ATAN_TAB[i];
    end else begin
      x_rot = x + y_sh;
      y_rot = y - x_sh;
      z_rot = z + ATAN_TAB[i];
    end
  end

endmodule

// File: rtl/cplx_polar_to_rect.sv
// cplx_polar_to_rect: iterative CORDIC polar (mag, angle Q3.28) to rect
// (re_out, im_out) converter; start/flush in, busy/done/range_err out.
module cplx_polar_to_rect
  import cplx_pkg::*;
#(
  parameter int ITER  = 24,
  parameter int GUARD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic        in_format,
  input  logic [31:0] mag,
  input  logic [31:0] angle,
  output logic [31:0] re_out,
  output logic [31:0] im_out,
  output logic        busy,
  output logic        done,
  output logic        range_err
);

  localparam int W = 34 + GUARD;
  localparam logic [4:0] LAST = 5'(ITER - 1);
  localparam logic signed [W-1:0] RND  = W'(1) <<< (GUARD - 1);
  localparam logic signed [W-1:0] MAXV = W'(64'sh7FFFFFFF);
  localparam logic signed [W-1:0] MINV = -MAXV - W'(1);

  state_t state;
  state_t state_nx;

  logic signed [W-1:0] x_q;
  logic signed [W-1:0] y_q;
  logic signed [31:0]  z_q;
  logic        [4:0]   i_q;
  logic        [31:0]  mag_q;
  logic signed [31:0]  ang_q;

  logic signed [W-1:0] x_rot;
  logic signed [W-1:0] y_rot;
  logic signed [31:0]  z_rot;

  logic signed [W-1:0] x_mag;
  logic signed [W-1:0] x0;
  logic signed [31:0]  z0;
  logic signed [31:0]  ang_in;
  logic                oor;

  function automatic logic [31:0] round_sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] t;
    t = (v + RND) >>> GUARD;
    if (t > MAXV) return 32'h7FFFFFFF;
    if (t < MINV) return 32'h80000000;
    return t[31:0];
  endfunction

  assign ang_in = $signed(angle);
  assign oor    = (ang_in > PI_Q) || (ang_in < -PI_Q);

  // Fold angles beyond +/-pi/2 by a half turn so the micro-rotations
  // only have to cover +/-pi/2; negating x0 supplies the half turn.
  always_comb begin
    x_mag = $signed(W'((64'(mag_q) * 64'(INV_K_Q31)) >> (31 - GUARD)));
    x0 = x_mag;
    z0 = ang_q;
    if (ang_q > HALF_PI_Q) begin
      z0 = ang_q - PI_Q;
      x0 = -x_mag;
    end else if (ang_q < -HALF_PI_Q) begin
      z0 = ang_q + PI_Q;
      x0 = -x_mag;
    end
  end

  cordic_rot_step #(
    .W(W)
  ) u_step (
    .x     (x_q),
    .y     (y_q),
    .z     (z_q),
    .i     (i_q),
    .x_rot (x_rot),
    .y_rot (y_rot),
    .z_rot (z_rot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!in_format || oor) state_nx = DONE;
          else                   state_nx = PRESCALE;
        end
      end
      PRESCALE: begin
        busy     = 1'b1;
        state_nx = ITERATE;
      end
      ITERATE: begin
        busy = 1'b1;
        if (i_q == LAST) state_nx = ROUND;
      end
      ROUND: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_out    <= '0;
      im_out    <= '0;
      range_err <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      i_q       <= '0;
      mag_q     <= '0;
      ang_q     <= '0;
    end else if (!flush) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            range_err <= 1'b0;
            if (!in_format) begin
              re_out <= mag;
              im_out <= angle;
            end else if (oor) begin
              re_out    <= '0;
              im_out    <= '0;
              range_err <= 1'b1;
            end else begin
              mag_q <= mag;
              ang_q <= ang_in;
            end
          end
        end
        PRESCALE: begin
          x_q <= x0;
          y_q <= '0;
          z_q <= z0;
          i_q <= '0;
        end
        ITERATE: begin
          x_q <= x_rot;
          y_q <= y_rot;
          z_q <= z_rot;
          i_q <= i_q + 5'd1;
        end
        ROUND: begin
          re_out <= round_sat(x_q);
          im_out <= round_sat(y_q);
        end
        default: ;
      endcase
    end
  end

endmodule
